// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the multi-cycle memory stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CNT_W = 4;

  // Number of address bits that select a byte within one data word.
  function automatic int byte_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous write and registered read, one-cycle read latency.
// No reset; contents survive a pipeline reset.
module mem_array #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle MEM stage: accepts one access in IDLE, stall_m for LATENCY cycles, done pulse after.
// Inputs ignored while BUSY/DONE; MEM_ALIGN_CHECK_EN enables misaligned-request rejection.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 13,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_access,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              halt,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              stall_m,
  output logic              align_err
);

  localparam int              OFF_W  = byte_off_w(DATA_W);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [DATA_W-1:0]       read_data_q, read_data_d;
  logic                    done_q, done_d;

  logic [ADDR_W-1:0]       addr_eff;
  logic                    misalign;
  logic                    req, accept, access;
  logic                    arr_we;
  logic [DEPTH_LOG2-1:0]   arr_idx;
  logic [DATA_W-1:0]       arr_wdata, arr_rdata;
  logic                    unused_addr;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |addr[OFF_W-1:0];
  assign addr_eff = addr;
`else
  assign misalign = 1'b0;
  assign addr_eff = {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
`endif
  assign unused_addr = ^addr;

  // Gated by rst so nothing is accepted or written while reset is held.
  assign req    = rst & mem_access & ~halt & (state_q == IDLE);
  assign accept = req & ~misalign;
  assign access = (accept && (LATENCY == 1)) ||
                  ((state_q == BUSY) && (cnt_q == CNT_W'(1)));

  // The access cycle uses live inputs only when it coincides with acceptance.
  assign arr_idx   = (state_q == IDLE) ? addr_eff[DEPTH_LOG2+OFF_W-1:OFF_W] : idx_q;
  assign arr_wdata = (state_q == IDLE) ? write_data : wdata_q;
  assign arr_we    = access & ((state_q == IDLE) ? mem_write : we_q);

  mem_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .idx  (arr_idx),
    .wdata(arr_wdata),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    read_data_d = read_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          idx_d   = addr_eff[DEPTH_LOG2+OFF_W-1:OFF_W];
          wdata_d = write_data;
          we_d    = mem_write;
          cnt_d   = LAT_M1;
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (!we_q) read_data_d = arr_rdata;
      end
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      read_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
    end
  end

  // In DONE the freshly read word is shown before it settles into read_data_q.
  assign read_data = ((state_q == DONE) && !we_q) ? arr_rdata : read_data_q;
  assign done      = done_q;
  assign stall_m   = accept | (state_q == BUSY);
  assign align_err = req & misalign;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: LATENCY=4 and LATENCY=1 instances driven in parallel,
// checked every cycle against a timestamp-based transaction model.
module tb_mem_stage_ctrl;

  localparam int DL = 4;
  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_access = 1'b0;
  logic        mem_write = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] write_data = '0;

  logic [15:0] rd0, rd1;
  logic        dn0, dn1, st0, st1, ae0, ae1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(DL), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .mem_access(mem_access), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .halt(halt),
    .read_data(rd0), .done(dn0), .stall_m(st0), .align_err(ae0)
  );

  mem_stage_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(DL), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .mem_access(mem_access), .mem_write(mem_write),
    .addr(addr), .write_data(write_data), .halt(halt),
    .read_data(rd1), .done(dn1), .stall_m(st1), .align_err(ae1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: an accepted op at cycle A stalls A..A+L-1, completes its access at the
  // end of A+L-1 and pulses done in A+L.
  int          lat   [2] = '{4, 1};
  logic [15:0] mm    [2][NW];
  bit          have  [2];
  int          acc   [2];
  bit          op_we [2];
  int          op_ix [2];
  logic [15:0] op_wd [2];
  logic [15:0] mrd   [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      have[i] = 1'b0;
      mrd[i]  = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        bit          idle, rq, algn, e_dn, e_st, e_ae;
        logic [15:0] a_rd;
        logic        a_dn, a_st, a_ae;
        a_rd = (i == 0) ? rd0 : rd1;
        a_dn = (i == 0) ? dn0 : dn1;
        a_st = (i == 0) ? st0 : st1;
        a_ae = (i == 0) ? ae0 : ae1;
        if (!rst) begin
          have[i] = 1'b0;
          mrd[i]  = '0;
          e_dn = 1'b0; e_st = 1'b0; e_ae = 1'b0;
        end else begin
          idle = !have[i];
          rq   = mem_access && !halt;
`ifdef MEM_ALIGN_CHECK_EN
          algn = (addr[0] == 1'b0);
`else
          algn = 1'b1;
`endif
          e_dn = have[i] && (cyc == acc[i] + lat[i]);
          e_st = (have[i] && (cyc < acc[i] + lat[i])) || (idle && rq && algn);
          e_ae = idle && rq && !algn;
        end
        chk($sformatf("i%0d_done", i), {31'd0, a_dn}, {31'd0, e_dn});
        chk($sformatf("i%0d_stall", i), {31'd0, a_st}, {31'd0, e_st});
        chk($sformatf("i%0d_align_err", i), {31'd0, a_ae}, {31'd0, e_ae});
        chk($sformatf("i%0d_read_data", i), {16'd0, a_rd}, {16'd0, mrd[i]});
        if (rst) begin
          if (!have[i] && mem_access && !halt && !e_ae) begin
            have[i]  = 1'b1;
            acc[i]   = cyc;
            op_we[i] = mem_write;
            op_ix[i] = (addr / 2) % NW;
            op_wd[i] = write_data;
          end
          if (have[i] && (cyc == acc[i] + lat[i] - 1)) begin
            if (op_we[i]) mm[i][op_ix[i]] = op_wd[i];
            else          mrd[i] = mm[i][op_ix[i]];
          end
          if (have[i] && (cyc == acc[i] + lat[i])) have[i] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic w, input logic [15:0] ad,
                       input logic [15:0] wd, input logic h);
    mem_access = a; mem_write = w; addr = ad; write_data = wd; halt = h;
  endtask

  // Single op for the LATENCY=4 instance; returns in cycle t0+5.
  task automatic do_op(input logic w, input logic [15:0] ad, input logic [15:0] wd);
    drive(1'b1, w, ad, wd, 1'b0);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) step();
  endtask

  initial begin
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    drive(1'b1, 1'b1, 16'h0010, 16'h1111, 1'b0);
    @(negedge clk);
    chk("rst_stall", {31'd0, st0}, 32'd0);
    chk("rst_read_data", {16'd0, rd0}, 32'd0);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NW; i++) do_op(1'b1, 16'(2 * i), 16'($urandom));

    // Store then load, LATENCY=4
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    @(negedge clk); chk("st_stall_t0", {31'd0, st0}, 32'd1);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); step();
    @(negedge clk); chk("st_stall_t3", {31'd0, st0}, 32'd1); chk("st_done_t3", {31'd0, dn0}, 32'd0);
    step();
    @(negedge clk); chk("st_done_t4", {31'd0, dn0}, 32'd1); chk("st_stall_t4", {31'd0, st0}, 32'd0);
    step();
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    @(negedge clk); chk("l1_stall_t0", {31'd0, st1}, 32'd1);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk); chk("l1_done_t1", {31'd0, dn1}, 32'd1); chk("l1_rd_t1", {16'd0, rd1}, 32'h0000BEEF);
    step(); step(); step();
    @(negedge clk); chk("ld_done_t4", {31'd0, dn0}, 32'd1); chk("ld_rd_t4", {16'd0, rd0}, 32'h0000BEEF);
    step();

    // Misaligned load
    drive(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0);
    @(negedge clk);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_align_err", {31'd0, ae0}, 32'd1); chk("mis_stall", {31'd0, st0}, 32'd0);
`else
    chk("mis_align_err", {31'd0, ae0}, 32'd0); chk("mis_stall", {31'd0, st0}, 32'd1);
`endif
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (4) step();
    @(negedge clk); chk("mis_rd", {16'd0, rd0}, 32'h0000BEEF);

    // Wrap-around with DEPTH_LOG2=4
    step();
    do_op(1'b1, 16'h0002, 16'h1234);
    do_op(1'b0, 16'h0022, 16'h0);
    @(negedge clk); chk("wrap_rd", {16'd0, rd0}, 32'h00001234);

    // Reset in the middle of a store
    step();
    drive(1'b1, 1'b1, 16'h0002, 16'hAAAA, 1'b0);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); rst = 1'b0;
    @(negedge clk);
    chk("mrst_stall", {31'd0, st0}, 32'd0); chk("mrst_done", {31'd0, dn0}, 32'd0);
    chk("mrst_rd", {16'd0, rd0}, 32'd0);
    step(); rst = 1'b1;
    step();
    do_op(1'b0, 16'h0002, 16'h0);
    @(negedge clk); chk("mrst_old_data", {16'd0, rd0}, 32'h00001234);

    // Halt handling
    step();
    drive(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1);
    @(negedge clk); chk("halt_idle_stall", {31'd0, st0}, 32'd0);
    step(); drive(1'b1, 1'b1, 16'h0004, 16'h5555, 1'b0);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step(); step(); step();
    @(negedge clk); chk("halt_busy_done", {31'd0, dn0}, 32'd1);
    step(); halt = 1'b0;
    step();

    // LATENCY=1 back-to-back
    drive(1'b1, 1'b0, 16'h0004, 16'h0, 1'b0);
    @(negedge clk); chk("b2b_stall_t0", {31'd0, st1}, 32'd1);
    step();
    @(negedge clk); chk("b2b_done_t1", {31'd0, dn1}, 32'd1); chk("b2b_stall_t1", {31'd0, st1}, 32'd0);
    chk("b2b_rd_t1", {16'd0, rd1}, 32'h00005555);
    step();
    @(negedge clk); chk("b2b_accept_t2", {31'd0, st1}, 32'd1);
    step(); drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (5) step();

    // Random traffic
    repeat (3000) begin
      rst        = ($urandom_range(0, 99) != 0);
      mem_access = 1'($urandom_range(0, 1));
      halt       = ($urandom_range(0, 4) == 0);
      mem_write  = 1'($urandom_range(0, 1));
      addr       = 16'($urandom);
      write_data = 16'($urandom);
      step();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
